// File: rtl/barrel_shift_arbiter.sv
// Two-requester arbiter that feeds a 4-bit logical right shifter into a one-deep result register.
// Define BSH_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority with requester 0 first.
module barrel_shift_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [3:0] req0_d,
   input  logic [1:0] req0_s,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [3:0] req1_d,
   input  logic [1:0] req1_s,
   output logic       req1_ready,
   output logic       res_valid,
   output logic [3:0] res_y,
   output logic       res_id,
   input  logic       res_ready,
   output logic [7:0] done_cnt
);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t     state;
   state_t     state_nx;
   logic       grant0;
   logic       grant1;
   logic       accept_ok;
   logic       accept;
   logic [3:0] gd;
   logic [1:0] gs;

`ifdef BSH_ARB_RR_EN
   // prio = 1 means requester 1 wins the next contention
   logic prio;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (prio) begin
         grant1 = req1_valid;
         grant0 = req0_valid & ~req1_valid;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid & ~req0_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         prio <= 1'b0;
      else if (accept)
         prio <= grant0;
   end
`else
   assign grant0 = req0_valid;
   assign grant1 = req1_valid & ~req0_valid;
`endif

   assign accept_ok  = (state == IDLE) | ((state == HOLD) & res_ready);
   assign req0_ready = grant0 & accept_ok & ~rst;
   assign req1_ready = grant1 & accept_ok & ~rst;
   assign accept     = req0_ready | req1_ready;
   assign gd         = grant1 ? req1_d : req0_d;
   assign gs         = grant1 ? req1_s : req0_s;
   assign res_valid  = (state == HOLD);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = HOLD;
         HOLD: if (res_ready & ~accept) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         res_y    <= 4'b0000;
         res_id   <= 1'b0;
         done_cnt <= 8'd0;
      end else begin
         state <= state_nx;
         if (accept) begin
            res_y  <= gd >> gs;
            res_id <= grant1;
         end
         if (res_valid & res_ready)
            done_cnt <= done_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed-vector bench for barrel_shift_arbiter.
// Checks reset, the shift sweep, backpressure, contention order, reset in HOLD and counter wrap.
module tb_barrel_shift_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_d, req1_d;
   logic [1:0] req0_s, req1_s;
   logic       req0_ready, req1_ready;
   logic       res_valid, res_id, res_ready;
   logic [3:0] res_y;
   logic [7:0] done_cnt;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   barrel_shift_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_d(req0_d),
      .req0_s(req0_s), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_d(req1_d),
      .req1_s(req1_s), .req1_ready(req1_ready),
      .res_valid(res_valid), .res_y(res_y),
      .res_id(res_id), .res_ready(res_ready),
      .done_cnt(done_cnt)
   );

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v0, input logic [3:0] d0,
                        input logic [1:0] s0, input logic v1,
                        input logic [3:0] d1, input logic [1:0] s1);
      req0_valid = v0; req0_d = d0; req0_s = s0;
      req1_valid = v1; req1_d = d1; req1_s = s1;
   endtask

   typedef struct {
      logic       id;
      logic [3:0] d;
      logic [1:0] s;
      logic [3:0] y;
   } vec_t;

   vec_t sweep [4];
   logic exp_ids [4];

   initial begin
      sweep[0] = '{1'b0, 4'b1011, 2'd0, 4'b1011};
      sweep[1] = '{1'b1, 4'b1011, 2'd1, 4'b0101};
      sweep[2] = '{1'b0, 4'b1011, 2'd3, 4'b0001};
      sweep[3] = '{1'b1, 4'b1111, 2'd0, 4'b1111};
`ifdef BSH_ARB_RR_EN
      exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

      // reset, with a request pending that must not be acknowledged
      rst = 1'b1;
      res_ready = 1'b0;
      drive(1'b1, 4'b1011, 2'd2, 1'b1, 4'b0110, 2'd1);
      #1;
      chk("rst_r0", {7'd0, req0_ready}, 8'd0);
      chk("rst_r1", {7'd0, req1_ready}, 8'd0);
      tick();
      tick();
      chk("rst_valid", {7'd0, res_valid}, 8'd0);
      chk("rst_y", {4'd0, res_y}, 8'd0);
      chk("rst_id", {7'd0, res_id}, 8'd0);
      chk("rst_cnt", done_cnt, 8'd0);
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);
      rst = 1'b0;
      tick();

      // single job
      res_ready = 1'b1;
      drive(1'b1, 4'b1011, 2'd2, 1'b0, 4'd0, 2'd0);
      #1;
      chk("one_r0", {7'd0, req0_ready}, 8'd1);
      chk("one_r1", {7'd0, req1_ready}, 8'd0);
      tick();
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);
      chk("one_valid", {7'd0, res_valid}, 8'd1);
      chk("one_y", {4'd0, res_y}, 8'b0010);
      chk("one_id", {7'd0, res_id}, 8'd0);
      tick();
      chk("one_drop", {7'd0, res_valid}, 8'd0);
      chk("one_cnt", done_cnt, 8'd1);

      // back-to-back shift sweep
      for (int i = 0; i < 4; i++) begin
         if (sweep[i].id)
            drive(1'b0, 4'd0, 2'd0, 1'b1, sweep[i].d, sweep[i].s);
         else
            drive(1'b1, sweep[i].d, sweep[i].s, 1'b0, 4'd0, 2'd0);
         #1;
         chk($sformatf("sw%0d_rdy", i),
             {7'd0, sweep[i].id ? req1_ready : req0_ready}, 8'd1);
         tick();
         chk($sformatf("sw%0d_y", i), {4'd0, res_y}, {4'd0, sweep[i].y});
         chk($sformatf("sw%0d_id", i), {7'd0, res_id}, {7'd0, sweep[i].id});
      end
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);
      tick();
      chk("sw_drop", {7'd0, res_valid}, 8'd0);
      chk("sw_cnt", done_cnt, 8'd5);

      // backpressure
      res_ready = 1'b0;
      drive(1'b1, 4'b1011, 2'd1, 1'b0, 4'd0, 2'd0);
      tick();
      drive(1'b0, 4'd0, 2'd0, 1'b1, 4'b1000, 2'd3);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("bp%0d_r1", i), {7'd0, req1_ready}, 8'd0);
         tick();
         chk($sformatf("bp%0d_y", i), {4'd0, res_y}, 8'b0101);
         chk($sformatf("bp%0d_v", i), {7'd0, res_valid}, 8'd1);
      end
      chk("bp_cnt", done_cnt, 8'd5);
      res_ready = 1'b1;
      #1;
      chk("bp_rel_r1", {7'd0, req1_ready}, 8'd1);
      tick();
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);
      chk("bp_rel_y", {4'd0, res_y}, 8'b0001);
      chk("bp_rel_id", {7'd0, res_id}, 8'd1);
      tick();
      chk("bp_done_cnt", done_cnt, 8'd7);

      // contention
      drive(1'b1, 4'b0001, 2'd0, 1'b1, 4'b0010, 2'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ct%0d_id", i), {7'd0, res_id}, {7'd0, exp_ids[i]});
         chk($sformatf("ct%0d_y", i), {4'd0, res_y},
             exp_ids[i] ? 8'b0010 : 8'b0001);
      end
      chk("ct_cnt", done_cnt, 8'd10);

      // reset while holding a result
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);
      res_ready = 1'b0;
      chk("rh_pre_v", {7'd0, res_valid}, 8'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rh_valid", {7'd0, res_valid}, 8'd0);
      chk("rh_y", {4'd0, res_y}, 8'd0);
      chk("rh_id", {7'd0, res_id}, 8'd0);
      chk("rh_cnt", done_cnt, 8'd0);
      drive(1'b1, 4'b0100, 2'd2, 1'b0, 4'd0, 2'd0);
      #1;
      chk("rh_idle_r0", {7'd0, req0_ready}, 8'd1);
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);

      // counter wrap
      res_ready = 1'b1;
      drive(1'b1, 4'b0110, 2'd1, 1'b0, 4'd0, 2'd0);
      for (int i = 0; i < 256; i++) tick();
      chk("wr_255", done_cnt, 8'd255);
      chk("wr_y", {4'd0, res_y}, 8'b0011);
      drive(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 2'd0);
      tick();
      chk("wr_0", done_cnt, 8'd0);
      chk("wr_drop", {7'd0, res_valid}, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
